// File: rtl/decode_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : decode_pkg                                                    |
// | Description : Shared defaults, control-bundle bit indices and E-stage       |
// |               update actions for the decode pipeline slice.                 |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package decode_pkg;

    localparam int XLEN_DEF      = 19;
    localparam int NREG_DEF      = 8;
    localparam int CTRL_W_DEF    = 12;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_LOAD     = 1;

    typedef enum logic [1:0] {
        E_LOAD   = 2'd0,
        E_HOLD   = 2'd1,
        E_BUBBLE = 2'd2,
        E_FLUSH  = 2'd3
    } eAction_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_p.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : reg_file_p                                                    |
// | Description : NREG x XLEN register file, one write port, two async reads.   |
// |               DECODE_WB_BYPASS_EN forwards the write data to matching reads.|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module reg_file_p
    import decode_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     writeEn,
    input  logic [$clog2(NREG)-1:0]  writeAddr,
    input  logic [XLEN-1:0]          writeData,
    input  logic [$clog2(NREG)-1:0]  readAddrA,
    input  logic [$clog2(NREG)-1:0]  readAddrB,
    output logic [XLEN-1:0]          readDataA,
    output logic [XLEN-1:0]          readDataB
);

    localparam int c_ADDR_W = $clog2(NREG);

    logic [XLEN-1:0]                r_regs [NREG];
    logic                           w_wrActive;
    logic [1:0][c_ADDR_W-1:0]       w_rAddr;
    logic [1:0][XLEN-1:0]           w_rData;

    assign w_wrActive = writeEn && !((R0_ZERO != 0) && (writeAddr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrActive) begin
            r_regs[writeAddr] <= writeData;
        end
    end

    assign w_rAddr = {readAddrB, readAddrA};

    for (genvar p = 0; p < 2; p++) begin : g_rdPort
        logic w_isZero;
        logic w_bypass;

        assign w_isZero = (R0_ZERO != 0) && (w_rAddr[p] == '0);
`ifdef DECODE_WB_BYPASS_EN
        assign w_bypass = w_wrActive && (writeAddr == w_rAddr[p]);
`else
        assign w_bypass = 1'b0;
`endif
        assign w_rData[p] = w_isZero ? '0 :
                            w_bypass ? writeData : r_regs[w_rAddr[p]];
    end

    assign readDataA = w_rData[0];
    assign readDataB = w_rData[1];

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : decode_pipe                                                   |
// | Description : D-stage register read, load-use hazard detection and the     |
// |               D->E pipeline register. Optional DECODE_WB_BYPASS_EN.        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     validD,
    input  logic [$clog2(NREG)-1:0]  rs1D,
    input  logic [$clog2(NREG)-1:0]  rs2D,
    input  logic [$clog2(NREG)-1:0]  rdD,
    input  logic                     useAD,
    input  logic                     useBD,
    input  logic [CTRL_W-1:0]        ctrlD,
    input  logic [XLEN-1:0]          immD,
    input  logic [XLEN-1:0]          pcD,
    input  logic [XLEN-1:0]          pcplus4D,
    input  logic                     regwriteW,
    input  logic [$clog2(NREG)-1:0]  rdW,
    input  logic [XLEN-1:0]          resultW,
    input  logic                     readyE,
    input  logic                     flushE,
    output logic                     validE,
    output logic [CTRL_W-1:0]        ctrlE,
    output logic [XLEN-1:0]          RD1E,
    output logic [XLEN-1:0]          RD2E,
    output logic [XLEN-1:0]          immE,
    output logic [XLEN-1:0]          pcE,
    output logic [XLEN-1:0]          pcplus4E,
    output logic [$clog2(NREG)-1:0]  rs1E,
    output logic [$clog2(NREG)-1:0]  rs2E,
    output logic [$clog2(NREG)-1:0]  rdE,
    output logic                     stallD
);

    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_eIsLoad;
    logic            w_rdEHazardable;
    logic            w_srcMatch;
    logic            w_loadHaz;
    eAction_t        w_eAction;

    reg_file_p #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .R0_ZERO (R0_ZERO)
    ) u_regFile (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (regwriteW),
        .writeAddr (rdW),
        .writeData (resultW),
        .readAddrA (rs1D),
        .readAddrB (rs2D),
        .readDataA (w_rd1),
        .readDataB (w_rd2)
    );

    // A load in E cannot forward its result to the instruction right behind it.
    assign w_eIsLoad       = validE && ctrlE[CTRL_LOAD] && ctrlE[CTRL_REGWRITE];
    assign w_rdEHazardable = !((R0_ZERO != 0) && (rdE == '0));
    assign w_srcMatch      = (useAD && (rs1D == rdE)) || (useBD && (rs2D == rdE));
    assign w_loadHaz       = validD && w_eIsLoad && w_srcMatch && w_rdEHazardable;

    assign stallD = validD && (w_loadHaz || !readyE) && !flushE;

    always_comb begin
        w_eAction = E_LOAD;
        if (flushE) begin
            w_eAction = E_FLUSH;
        end else if (!readyE) begin
            w_eAction = E_HOLD;
        end else if (w_loadHaz) begin
            w_eAction = E_BUBBLE;
        end
    end

    // Data fields are left untouched on flush/bubble; only valid/ctrl matter then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE   <= 1'b0;
            ctrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            immE     <= '0;
            pcE      <= '0;
            pcplus4E <= '0;
            rs1E     <= '0;
            rs2E     <= '0;
            rdE      <= '0;
        end else begin
            case (w_eAction)
                E_FLUSH, E_BUBBLE: begin
                    validE <= 1'b0;
                    ctrlE  <= '0;
                end
                E_LOAD: begin
                    validE   <= validD;
                    ctrlE    <= validD ? ctrlD : '0;
                    RD1E     <= w_rd1;
                    RD2E     <= w_rd2;
                    immE     <= immD;
                    pcE      <= pcD;
                    pcplus4E <= pcplus4D;
                    rs1E     <= rs1D;
                    rs2E     <= rs2D;
                    rdE      <= rdD;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_decode_pipe                                                |
// | Description : Self-checking bench for decode_pipe (R0_ZERO=0 and =1 copies) |
// |               against a behavioural model; honours DECODE_WB_BYPASS_EN.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_decode_pipe;

    localparam int XLEN = 19;
    localparam int NR   = 8;
    localparam int AW   = 3;
    localparam int CW   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic validD = 1'b0, useAD = 1'b0, useBD = 1'b0;
    logic regwriteW = 1'b0, readyE = 1'b1, flushE = 1'b0;
    logic [AW-1:0]   rs1D = '0, rs2D = '0, rdD = '0, rdW = '0;
    logic [CW-1:0]   ctrlD = '0;
    logic [XLEN-1:0] immD = '0, pcD = '0, pcplus4D = '0, resultW = '0;

    logic [1:0]             validE, stallD;
    logic [1:0][CW-1:0]     ctrlE;
    logic [1:0][XLEN-1:0]   rd1E, rd2E, immE, pcE, pc4E;
    logic [1:0][AW-1:0]     rs1E, rs2E, rdE;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        decode_pipe #(.XLEN(XLEN), .NREG(NR), .CTRL_W(CW), .R0_ZERO(k)) u_dut (
            .clk(clk), .rst(rst), .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
            .useAD(useAD), .useBD(useBD), .ctrlD(ctrlD), .immD(immD), .pcD(pcD),
            .pcplus4D(pcplus4D), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
            .readyE(readyE), .flushE(flushE), .validE(validE[k]), .ctrlE(ctrlE[k]),
            .RD1E(rd1E[k]), .RD2E(rd2E[k]), .immE(immE[k]), .pcE(pcE[k]),
            .pcplus4E(pc4E[k]), .rs1E(rs1E[k]), .rs2E(rs2E[k]), .rdE(rdE[k]),
            .stallD(stallD[k])
        );
    end

    // Reference state: architectural registers plus what E should currently hold.
    logic [XLEN-1:0] mrf [2][NR];
    logic            mV [2];
    logic [CW-1:0]   mC [2];
    logic [XLEN-1:0] mR1 [2], mR2 [2], mImm [2], mPc [2], mPc4 [2];
    logic [AW-1:0]   mS1 [2], mS2 [2], mRd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rdPort(input int k, input logic [AW-1:0] a);
        if (k == 1 && a == '0) return '0;
`ifdef DECODE_WB_BYPASS_EN
        if (regwriteW && rdW == a) return resultW;
`endif
        return mrf[k][a];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NR; r++) mrf[k][r] = '0;
            mV[k] = 1'b0; mC[k] = '0; mR1[k] = '0; mR2[k] = '0; mImm[k] = '0;
            mPc[k] = '0; mPc4[k] = '0; mS1[k] = '0; mS2[k] = '0; mRd[k] = '0;
        end
    endtask

    task automatic checkE(input bit full);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("validE%0d", k), 32'(validE[k]), 32'(mV[k]));
            chk($sformatf("ctrlE%0d", k), 32'(ctrlE[k]), 32'(mC[k]));
            if (full || mV[k]) begin
                chk($sformatf("RD1E%0d", k), 32'(rd1E[k]), 32'(mR1[k]));
                chk($sformatf("RD2E%0d", k), 32'(rd2E[k]), 32'(mR2[k]));
                chk($sformatf("immE%0d", k), 32'(immE[k]), 32'(mImm[k]));
                chk($sformatf("pcE%0d", k), 32'(pcE[k]), 32'(mPc[k]));
                chk($sformatf("pcplus4E%0d", k), 32'(pc4E[k]), 32'(mPc4[k]));
                chk($sformatf("rs1E%0d", k), 32'(rs1E[k]), 32'(mS1[k]));
                chk($sformatf("rs2E%0d", k), 32'(rs2E[k]), 32'(mS2[k]));
                chk($sformatf("rdE%0d", k), 32'(rdE[k]), 32'(mRd[k]));
            end
        end
    endtask

    // Check stallD with the current inputs, advance one edge, check E.
    task automatic step();
        logic            nV [2];
        logic [CW-1:0]   nC [2];
        logic [XLEN-1:0] n1 [2], n2 [2], nI [2], nP [2], nP4 [2];
        logic [AW-1:0]   nS1 [2], nS2 [2], nRd [2];
        bit haz;
        #1;
        for (int k = 0; k < 2; k++) begin
            haz = validD && mV[k] && mC[k][1] && mC[k][0] &&
                  ((useAD && rs1D == mRd[k]) || (useBD && rs2D == mRd[k])) &&
                  !(k == 1 && mRd[k] == '0);
            chk($sformatf("stallD%0d", k), 32'(stallD[k]),
                32'(validD && (haz || !readyE) && !flushE));
            nV[k] = mV[k]; nC[k] = mC[k]; n1[k] = mR1[k]; n2[k] = mR2[k];
            nI[k] = mImm[k]; nP[k] = mPc[k]; nP4[k] = mPc4[k];
            nS1[k] = mS1[k]; nS2[k] = mS2[k]; nRd[k] = mRd[k];
            if (flushE || (readyE && haz)) begin
                nV[k] = 1'b0; nC[k] = '0;
            end else if (readyE) begin
                nV[k] = validD; nC[k] = validD ? ctrlD : '0;
                n1[k] = rdPort(k, rs1D); n2[k] = rdPort(k, rs2D);
                nI[k] = immD; nP[k] = pcD; nP4[k] = pcplus4D;
                nS1[k] = rs1D; nS2[k] = rs2D; nRd[k] = rdD;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mV[k] = nV[k]; mC[k] = nC[k]; mR1[k] = n1[k]; mR2[k] = n2[k];
            mImm[k] = nI[k]; mPc[k] = nP[k]; mPc4[k] = nP4[k];
            mS1[k] = nS1[k]; mS2[k] = nS2[k]; mRd[k] = nRd[k];
            if (regwriteW && !(k == 1 && rdW == '0)) mrf[k][rdW] = resultW;
        end
        checkE(1'b0);
    endtask

    initial begin
        // Reset state
        #3;
        modelReset();
        checkE(1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Pass-through: write r2, then read it into E
        regwriteW = 1'b1; rdW = 3'd2; resultW = 19'h1234;
        step();
        regwriteW = 1'b0; validD = 1'b1; rs1D = 3'd2; useAD = 1'b1; pcD = 19'h40;
        ctrlD = 12'h000; rdD = 3'd6;
        step();
        chk("pass_valid", 32'(validE[0]), 32'd1);
        chk("pass_rd1", 32'(rd1E[0]), 32'h1234);
        chk("pass_pc", 32'(pcE[0]), 32'h40);

        // Load-use: load to r5, then consumer of r5 on port B
        ctrlD = 12'h003; rdD = 3'd5; useAD = 1'b0; rs1D = 3'd1;
        step();
        ctrlD = 12'h001; rdD = 3'd1; rs2D = 3'd5; useBD = 1'b1; pcD = 19'h44;
        #1;
        chk("lu_stall", 32'(stallD[0]), 32'd1);
        step();
        chk("lu_bubble_valid", 32'(validE[0]), 32'd0);
        chk("lu_bubble_ctrl", 32'(ctrlE[0]), 32'd0);
        step();
        chk("lu_issue_valid", 32'(validE[0]), 32'd1);
        chk("lu_issue_pc", 32'(pcE[0]), 32'h44);

        // Backpressure for three cycles, then flush while still not ready
        useBD = 1'b0; ctrlD = 12'h0A4; pcD = 19'h48; readyE = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("bp_pc_held", 32'(pcE[0]), 32'h44);
        flushE = 1'b1;
        #1;
        chk("flush_stall", 32'(stallD[0]), 32'd0);
        step();
        chk("flush_valid", 32'(validE[0]), 32'd0);
        flushE = 1'b0; readyE = 1'b1;

        // Writeback bypass on the same cycle as the read
        validD = 1'b0; regwriteW = 1'b1; rdW = 3'd4; resultW = 19'h0ABC;
        step();
        resultW = 19'h7FFFF; validD = 1'b1; rs1D = 3'd4; useAD = 1'b1; ctrlD = 12'h000;
        step();
`ifdef DECODE_WB_BYPASS_EN
        chk("bypass_rd1", 32'(rd1E[0]), 32'h7FFFF);
`else
        chk("bypass_rd1", 32'(rd1E[0]), 32'h0ABC);
`endif
        regwriteW = 1'b0;
        step();
        chk("wb_visible", 32'(rd1E[0]), 32'h7FFFF);

        // Register 0 behaviour and a load to rd=0
        validD = 1'b0; regwriteW = 1'b1; rdW = 3'd0; resultW = 19'h55;
        step();
        regwriteW = 1'b0; validD = 1'b1; rs1D = 3'd0; useAD = 1'b1;
        step();
        chk("r0_zero_read", 32'(rd1E[1]), 32'd0);
        chk("r0_plain_read", 32'(rd1E[0]), 32'h55);
        ctrlD = 12'h003; rdD = 3'd0; useAD = 1'b0;
        step();
        ctrlD = 12'h000; rdD = 3'd1; useAD = 1'b1;
        #1;
        chk("r0_no_stall", 32'(stallD[1]), 32'd0);
        chk("r0_plain_stall", 32'(stallD[0]), 32'd1);
        step();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            validD    = 1'($urandom_range(0, 1));
            useAD     = 1'($urandom_range(0, 1));
            useBD     = 1'($urandom_range(0, 1));
            rs1D      = AW'($urandom);
            rs2D      = AW'($urandom);
            rdD       = AW'($urandom);
            ctrlD     = CW'($urandom);
            immD      = XLEN'($urandom);
            pcD       = XLEN'($urandom);
            pcplus4D  = XLEN'($urandom);
            regwriteW = 1'($urandom_range(0, 1));
            rdW       = AW'($urandom);
            resultW   = XLEN'($urandom);
            readyE    = ($urandom_range(0, 4) != 0);
            flushE    = ($urandom_range(0, 9) == 0);
            step();
        end

        // Asynchronous reset while E is stalled and a writeback is in flight
        flushE = 1'b0; readyE = 1'b1; validD = 1'b1; ctrlD = 12'h5A1; pcD = 19'h3C0;
        step();
        readyE = 1'b0; regwriteW = 1'b1; rdW = 3'd3; resultW = 19'h2AAAA;
        step();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkE(1'b1);
        regwriteW = 1'b0; readyE = 1'b1; rs1D = 3'd3; useAD = 1'b1; useBD = 1'b0;
        ctrlD = 12'h000;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_reset_r3", 32'(rd1E[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 19: datapath, PC and immediate width.
REQ-002 SHALL have parameter NREG, default 8: register count; REG_AW = clog2(NREG).
REQ-003 SHALL have parameter CTRL_W, default 12: width of the opaque control bundle from the decoder.
REQ-004 SHALL have parameter R0_ZERO, default 0: 1 makes register 0 read as zero and ignore writes.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 validD  in  1  D-stage instruction present.
REQ-008 rs1D, rs2D, rdD  in  REG_AW each  source and destination register addresses.
REQ-009 useAD, useBD  in  1 each  instruction actually reads rs1D / rs2D.
REQ-010 ctrlD  in  CTRL_W  decoded controls; bit 0 = regwrite, bit 1 = load (resultsrc).
REQ-011 immD, pcD, pcplus4D  in  XLEN each.
REQ-012 regwriteW  in  1; rdW  in  REG_AW; resultW  in  XLEN: writeback port.
REQ-013 readyE  in  1  E stage accepts; flushE  in  1  kill E-register contents (taken branch/jump).
REQ-014 validE  out  1; ctrlE  out  CTRL_W; RD1E, RD2E, immE, pcE, pcplus4E  out  XLEN; rs1E, rs2E, rdE  out  REG_AW.
REQ-015 stallD  out  1  combinational: D must hold its instruction this cycle.

Function
REQ-016 SHALL contain an NREG x XLEN register file, written on the rising clk edge when regwriteW=1 (and rdW!=0 if R0_ZERO), two combinational read ports addressed by rs1D and rs2D.
REQ-017 loadhaz SHALL be 1 when validE & ctrlE[1] & ctrlE[0] & ((useAD & rs1D==rdE) | (useBD & rs2D==rdE)) & validD; with R0_ZERO, rdE==0 never hazards.
REQ-018 stallD SHALL be validD & (loadhaz | !readyE) & !flushE.
REQ-019 E-register update each edge, priority order: (a) flushE=1 -> validE<=0, ctrlE<=0; (b) else readyE=0 -> hold all E outputs; (c) else loadhaz=1 -> bubble: validE<=0, ctrlE<=0; (d) else load all D fields, validE<=validD, ctrlE<=validD ? ctrlD : 0.
REQ-020 Latency D->E SHALL be exactly one cycle when no stall; a load-use bubble SHALL last exactly one cycle.
REQ-021 Held E contents SHALL stay bit-identical for the whole readyE=0 interval.
REQ-022 When validE=0, ctrlE SHALL be all-zero; other E data fields are don't-care.
REQ-023 Writeback SHALL proceed regardless of stall, flush or readyE.
REQ-024 Widths SHALL be exact; no truncation or extension of any XLEN field.

Reset
REQ-025 rst=0 SHALL immediately clear validE, ctrlE, RD1E, RD2E, immE, pcE, pcplus4E, rs1E, rs2E, rdE and every register-file entry to 0, including mid-stall or mid-writeback.
REQ-026 The first edge after rst deasserts SHALL behave per REQ-019 with all-zero prior state (no hazard possible).

Configuration
REQ-027 Macro DECODE_WB_BYPASS_EN defined: a read port whose address equals rdW while regwriteW=1 (and not suppressed by R0_ZERO) SHALL return resultW in the same cycle.
REQ-028 Macro undefined: read ports SHALL return the pre-write register contents; the new value is visible from the next cycle.

Structure
REQ-029 Shared package decode_pkg SHALL hold the ctrl bit indices (CTRL_REGWRITE=0, CTRL_LOAD=1), the CTRL_W default, and the XLEN/NREG defaults.
REQ-030 Register file SHALL be a separate sub-module reg_file_p (parameters XLEN, NREG, R0_ZERO); hazard logic and E register stay in decode_pipe.

Verification
REQ-031 Reset: rst=0 while E holds data -> all outputs 0 immediately; after release, read r3 = 0.
REQ-032 Pass-through: write r2=19'h1234; next cycle validD=1, rs1D=2, pcD=19'h40, readyE=1 -> after one edge validE=1, RD1E=19'h1234, pcE=19'h40.
REQ-033 Load-use: E holds load with rdE=5; D uses rs2D=5, useBD=1 -> stallD=1 for one cycle, validE=0/ctrlE=0 on the next edge, then instruction appears.
REQ-034 Backpressure + flush: readyE=0 for 3 cycles -> E stable, stallD=1; flushE=1 with readyE=0 -> validE=0 next edge, stallD=0.
REQ-035 Bypass: regwriteW=1, rdW=4, resultW=19'h7FFFF, rs1D=4 same cycle -> RD1E=19'h7FFFF with DECODE_WB_BYPASS_EN, old r4 value without.
REQ-036 R0_ZERO=1: write r0=19'h55 -> read r0 = 0; load to rdE=0 with rs1D=0 -> no stall.
